// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus; one grant per transaction.
// Optional slave-response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  gnt,
    output logic        timeout_err
);

    // Encoding chosen so the state register doubles as the one-hot grant.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic        last, last_nxt;
    logic        sel1;
    logic        o_valid;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    assign gnt     = state;
    assign sel1    = (state == BUSY1);
    assign o_valid = sel1 ? m1_valid : m0_valid;
    assign o_addr  = sel1 ? m1_addr  : m0_addr;
    assign o_wdata = sel1 ? m1_wdata : m0_wdata;
    assign o_wstrb = sel1 ? m1_wstrb : m0_wstrb;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Held at zero while idle, so it is already clear on entry to BUSYx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (!s_ready) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // wd_cnt holds the number of earlier stalled BUSY cycles, so this fires on the
    // TIMEOUT_CYCLES-th stalled cycle.
    assign expired = (state != IDLE) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, ERR_RDATA};
    assign expired    = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        rsp_ready   = 1'b0;
        rsp_rdata   = '0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last)) begin
                    state_nxt = BUSY0;
                    last_nxt  = 1'b0;
                end else if (m1_valid) begin
                    state_nxt = BUSY1;
                    last_nxt  = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                s_valid   = o_valid;
                s_addr    = o_addr;
                s_wdata   = o_wdata;
                s_wstrb   = o_wstrb;
                rsp_rdata = s_rdata;
                // Abort first, then completion, then watchdog: a late s_ready still wins.
                if (!o_valid) begin
                    state_nxt = IDLE;
                end else if (s_ready) begin
                    rsp_ready = 1'b1;
                    state_nxt = IDLE;
                end else if (expired) begin
                    s_valid     = 1'b0;
                    rsp_ready   = 1'b1;
                    rsp_rdata   = ERR_RDATA;
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_ready = rsp_ready && (state == BUSY0);
    assign m1_ready = rsp_ready && sel1;
    assign m0_rdata = (state == BUSY0) ? rsp_rdata : '0;
    assign m1_rdata = sel1 ? rsp_rdata : '0;

endmodule
